// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the scratch-RAM arbiter: default geometry,
// sequencer states and requester identifiers.
package ram_arbiter_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. The pointer names the requester that wins
// the next contention and flips to the other side after every grant.
module rr_arb2
  import ram_arbiter_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_req,
  input  logic       i_enable,
  output logic [1:0] o_gnt
);

  logic r_ptr;

  // Grant a lone requester outright; on contention the pointer decides.
  always_comb begin
    o_gnt = '0;
    if (i_enable) begin
      if (i_req[REQ_A] && (!i_req[REQ_B] || (r_ptr == REQ_A))) begin
        o_gnt[REQ_A] = 1'b1;
      end else if (i_req[REQ_B]) begin
        o_gnt[REQ_B] = 1'b1;
      end
    end
  end

  // Hand priority to the other requester after each grant; hold when idle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ptr <= REQ_A;
    end else if (o_gnt[REQ_A]) begin
      r_ptr <= REQ_B;
    end else if (o_gnt[REQ_B]) begin
      r_ptr <= REQ_A;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and sequencer for the scratch RAM. Zero-fills the
// array after reset, then grants one single-cycle read or write per cycle
// to requester A or B and returns read data on a per-requester strobe.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_a_valid,
  output logic              o_a_ready,
  input  logic              i_a_write,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_wdata,
  output logic              o_a_rsp_valid,
  output logic [DATA_W-1:0] o_a_rsp_data,
  input  logic              i_b_valid,
  output logic              o_b_ready,
  input  logic              i_b_write,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [DATA_W-1:0] i_b_wdata,
  output logic              o_b_rsp_valid,
  output logic [DATA_W-1:0] o_b_rsp_data,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_din,
  output logic              o_ram_ri,
  input  logic [DATA_W-1:0] i_ram_dout,
  output logic              o_busy
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              r_pend_valid;
  logic              r_pend_id;
  logic [DATA_W-1:0] r_a_data;
  logic [DATA_W-1:0] r_b_data;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_din;

  logic       w_run;
  logic       w_enable;
  logic [1:0] w_gnt;
  logic       w_rd_accept;
  logic       w_a_rsp;
  logic       w_b_rsp;

  assign w_run    = (r_state == ST_RUN);
  assign w_enable = w_run && !i_reset;
  assign o_busy   = (r_state == ST_CLEAR);

  rr_arb2 u_arb (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_req    ({i_b_valid, i_a_valid}),
    .i_enable (w_enable),
    .o_gnt    (w_gnt)
  );

  // A read is accepted when the granted requester is not writing.
  assign w_rd_accept = (w_gnt[REQ_A] && !i_a_write) || (w_gnt[REQ_B] && !i_b_write);

  // The response strobe follows an accepted read by one cycle and is masked by reset.
  assign w_a_rsp = r_pend_valid && (r_pend_id == REQ_A) && !i_reset;
  assign w_b_rsp = r_pend_valid && (r_pend_id == REQ_B) && !i_reset;

  // Read data passes straight through on the strobe cycle and is held afterwards.
  always_comb begin
    o_a_rsp_valid = w_a_rsp;
    o_b_rsp_valid = w_b_rsp;
    o_a_rsp_data  = w_a_rsp ? i_ram_dout : r_a_data;
    o_b_rsp_data  = w_b_rsp ? i_ram_dout : r_b_data;
    if (i_reset) begin
      o_a_rsp_data = '0;
      o_b_rsp_data = '0;
    end
  end

  // Steer the RAM pins: forced low in reset, sweeping zeros while clearing,
  // otherwise the granted requester's transaction or the held address.
  always_comb begin
    o_a_ready  = 1'b0;
    o_b_ready  = 1'b0;
    o_ram_ri   = 1'b0;
    o_ram_addr = r_ram_addr;
    o_ram_din  = r_ram_din;
    if (i_reset) begin
      o_ram_addr = '0;
      o_ram_din  = '0;
    end else if (!w_run) begin
      o_ram_addr = r_clr_cnt;
      o_ram_din  = '0;
      o_ram_ri   = 1'b1;
    end else if (w_gnt[REQ_A]) begin
      o_a_ready  = 1'b1;
      o_ram_addr = i_a_addr;
      o_ram_din  = i_a_wdata;
      o_ram_ri   = i_a_write;
    end else if (w_gnt[REQ_B]) begin
      o_b_ready  = 1'b1;
      o_ram_addr = i_b_addr;
      o_ram_din  = i_b_wdata;
      o_ram_ri   = i_b_write;
    end
  end

  // Sequencer: clear sweep, read-response pipeline and held pin values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      if (CLEAR_ON_RESET != 0) begin
        r_state <= ST_CLEAR;
      end else begin
        r_state <= ST_RUN;
      end
      r_clr_cnt    <= '0;
      r_pend_valid <= 1'b0;
      r_pend_id    <= REQ_A;
      r_a_data     <= '0;
      r_b_data     <= '0;
      r_ram_addr   <= '0;
      r_ram_din    <= '0;
    end else begin
      r_ram_addr <= o_ram_addr;
      r_ram_din  <= o_ram_din;
      if (w_a_rsp) begin
        r_a_data <= i_ram_dout;
      end
      if (w_b_rsp) begin
        r_b_data <= i_ram_dout;
      end
      case (r_state)
        ST_CLEAR: begin
          r_pend_valid <= 1'b0;
          r_clr_cnt    <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == '1) begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_pend_valid <= w_rd_accept;
          r_pend_id    <= w_gnt[REQ_B] ? REQ_B : REQ_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a behavioural RAM on the pins, a transaction-level
// model of memory contents, priority and pending responses, directed
// scenarios followed by constrained-random traffic.
module tb_ram_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       aValid, aWrite, bValid, bWrite;
  logic [3:0] aAddr, bAddr;
  logic [7:0] aWdata, bWdata;
  logic       aReady, bReady, aRspValid, bRspValid;
  logic [7:0] aRspData, bRspData;
  logic [3:0] ramAddr;
  logic [7:0] ramDin, ramDout;
  logic       ramRi, busy;

  logic [7:0] ramArray [16];

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model state
  logic [7:0] mdlMem [16];
  int         mdlPtr;
  int         mdlClrIdx;
  bit         mdlPendValid;
  int         mdlPendId;
  logic [7:0] mdlPendData;
  logic [7:0] mdlAData, mdlBData;
  logic [3:0] mdlLastAddr;
  bit         mdlGntA, mdlGntB;

  always #5 clock = ~clock;

  // Behavioural synchronous RAM: write on the edge, read data registered.
  always @(posedge clock) begin
    if (ramRi) ramArray[ramAddr] <= ramDin;
    ramDout <= ramArray[ramAddr];
  end

  ram_arbiter dut (
    .i_clk(clock), .i_reset(reset),
    .i_a_valid(aValid), .o_a_ready(aReady), .i_a_write(aWrite), .i_a_addr(aAddr),
    .i_a_wdata(aWdata), .o_a_rsp_valid(aRspValid), .o_a_rsp_data(aRspData),
    .i_b_valid(bValid), .o_b_ready(bReady), .i_b_write(bWrite), .i_b_addr(bAddr),
    .i_b_wdata(bWdata), .o_b_rsp_valid(bRspValid), .o_b_rsp_data(bRspData),
    .o_ram_addr(ramAddr), .o_ram_din(ramDin), .o_ram_ri(ramRi),
    .i_ram_dout(ramDout), .o_busy(busy)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Compare every output against what the model predicts for this cycle.
  task automatic checkOutput();
    bit expRspA, expRspB;
    if (reset) begin
      checkVal("rst_a_ready", aReady, 0);
      checkVal("rst_b_ready", bReady, 0);
      checkVal("rst_a_rsp_valid", aRspValid, 0);
      checkVal("rst_b_rsp_valid", bRspValid, 0);
      checkVal("rst_a_rsp_data", aRspData, 0);
      checkVal("rst_b_rsp_data", bRspData, 0);
      checkVal("rst_ram_ri", ramRi, 0);
      checkVal("rst_ram_addr", ramAddr, 0);
      checkVal("rst_ram_din", ramDin, 0);
      return;
    end
    if (mdlClrIdx < 16) begin
      checkVal("clr_busy", busy, 1);
      checkVal("clr_ram_addr", ramAddr, mdlClrIdx);
      checkVal("clr_ram_din", ramDin, 0);
      checkVal("clr_ram_ri", ramRi, 1);
      checkVal("clr_a_ready", aReady, 0);
      checkVal("clr_b_ready", bReady, 0);
      checkVal("clr_rsp_valid", {aRspValid, bRspValid}, 0);
      mdlGntA = 0;
      mdlGntB = 0;
      return;
    end
    mdlGntA = aValid && (!bValid || mdlPtr == 0);
    mdlGntB = bValid && !mdlGntA;
    expRspA = mdlPendValid && mdlPendId == 0;
    expRspB = mdlPendValid && mdlPendId == 1;
    checkVal("run_busy", busy, 0);
    checkVal("a_ready", aReady, mdlGntA);
    checkVal("b_ready", bReady, mdlGntB);
    if (mdlGntA) begin
      checkVal("ram_addr_a", ramAddr, aAddr);
      checkVal("ram_ri_a", ramRi, aWrite);
      if (aWrite) checkVal("ram_din_a", ramDin, aWdata);
    end else if (mdlGntB) begin
      checkVal("ram_addr_b", ramAddr, bAddr);
      checkVal("ram_ri_b", ramRi, bWrite);
      if (bWrite) checkVal("ram_din_b", ramDin, bWdata);
    end else begin
      checkVal("ram_addr_hold", ramAddr, mdlLastAddr);
      checkVal("ram_ri_idle", ramRi, 0);
    end
    checkVal("a_rsp_valid", aRspValid, expRspA);
    checkVal("b_rsp_valid", bRspValid, expRspB);
    checkVal("a_rsp_data", aRspData, expRspA ? mdlPendData : mdlAData);
    checkVal("b_rsp_data", bRspData, expRspB ? mdlPendData : mdlBData);
  endtask

  // Advance the model across one clock edge.
  task automatic updateModel();
    if (reset) begin
      mdlClrIdx = 0; mdlPtr = 0; mdlPendValid = 0;
      mdlAData = 0; mdlBData = 0; mdlLastAddr = 0;
      mdlGntA = 0; mdlGntB = 0;
      return;
    end
    if (mdlClrIdx < 16) begin
      mdlMem[mdlClrIdx] = 8'h00;
      mdlLastAddr = 4'(mdlClrIdx);
      mdlClrIdx++;
      return;
    end
    if (mdlPendValid && mdlPendId == 0) mdlAData = mdlPendData;
    if (mdlPendValid && mdlPendId == 1) mdlBData = mdlPendData;
    mdlPendValid = 0;
    if (mdlGntA) begin
      mdlPtr = 1;
      mdlLastAddr = aAddr;
      if (aWrite) mdlMem[aAddr] = aWdata;
      else begin mdlPendValid = 1; mdlPendId = 0; mdlPendData = mdlMem[aAddr]; end
    end else if (mdlGntB) begin
      mdlPtr = 0;
      mdlLastAddr = bAddr;
      if (bWrite) mdlMem[bAddr] = bWdata;
      else begin mdlPendValid = 1; mdlPendId = 1; mdlPendData = mdlMem[bAddr]; end
    end
  endtask

  // Drive one cycle of requester inputs, check mid-cycle, then step the model.
  task automatic applyStimulus(input bit av, input bit aw, input logic [3:0] aa, input logic [7:0] ad,
                               input bit bv, input bit bw, input logic [3:0] ba, input logic [7:0] bd);
    aValid = av; aWrite = aw; aAddr = aa; aWdata = ad;
    bValid = bv; bWrite = bw; bAddr = ba; bWdata = bd;
    @(negedge clock);
    checkOutput();
    @(posedge clock);
    updateModel();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
  endtask

  initial begin
    bit av, aw, bv, bw;
    logic [3:0] aa, ba;
    logic [7:0] ad, bd;
    reset = 1'b1;
    mdlClrIdx = 0;

    $display("[TB] reset and clear sweep with A already requesting");
    doReset();
    for (int i = 0; i < 16; i++) applyStimulus(1, 0, 4'h7, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 4'h7, 0, 0, 0, 0, 0);
    idle(1);

    $display("[TB] write then read-back on A");
    applyStimulus(1, 1, 4'h3, 8'h5A, 0, 0, 0, 0);
    applyStimulus(1, 0, 4'h3, 8'h00, 0, 0, 0, 0);
    idle(1);
    checkVal("a_held_5A", aRspData, 8'h5A);

    $display("[TB] continuous contention alternates");
    for (int i = 0; i < 6; i++) applyStimulus(1, 0, 4'h1, 0, 1, 0, 4'h2, 0);
    idle(1);

    $display("[TB] B alone then contention");
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 0, 4'h4, 0);
    checkVal("ptr_after_b_only", mdlPtr, 0);
    applyStimulus(1, 0, 4'h5, 0, 1, 0, 4'h6, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 4'h6, 0);
    idle(1);

    $display("[TB] same-address conflict");
    applyStimulus(1, 1, 4'h9, 8'hC3, 1, 0, 4'h9, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 4'h9, 0);
    idle(1);
    checkVal("b_held_C3", bRspData, 8'hC3);

    $display("[TB] reset right after an accepted read");
    applyStimulus(1, 0, 4'h3, 0, 0, 0, 0, 0);
    doReset();
    for (int i = 0; i < 16; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 4'h3, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 4'h9, 0);
    idle(1);
    checkVal("b_after_reclear", bRspData, 8'h00);

    $display("[TB] random traffic");
    av = 0; bv = 0; aw = 0; bw = 0; aa = 0; ba = 0; ad = 0; bd = 0;
    for (int i = 0; i < 300; i++) begin
      if (!(av && !mdlGntA)) begin
        av = 1'($urandom_range(0, 1)); aw = 1'($urandom_range(0, 1));
        aa = 4'($urandom_range(0, 15)); ad = 8'($urandom);
      end
      if (!(bv && !mdlGntB)) begin
        bv = 1'($urandom_range(0, 1)); bw = 1'($urandom_range(0, 1));
        ba = 4'($urandom_range(0, 15)); bd = 8'($urandom);
      end
      applyStimulus(av, aw, aa, ad, bv, bw, ba, bd);
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
